// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer:
// state encoding, mode codes, initial patterns and small decode helpers.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLINK = 2'd1,
        ST_CHASE = 2'd2,
        ST_FILL  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_BLINK = 2'b00;
    localparam logic [1:0] MODE_CHASE = 2'b01;
    localparam logic [1:0] MODE_FILL  = 2'b10;
    localparam logic [1:0] MODE_OFF   = 2'b11;

    localparam logic [15:0] PAT_IDLE  = 16'h0000;
    localparam logic [15:0] PAT_BLINK = 16'hFFFF;
    localparam logic [15:0] PAT_CHASE = 16'h0001;
    localparam logic [15:0] PAT_FILL  = 16'h0001;

    // Map the external mode code onto the FSM state it selects.
    function automatic state_t mode_to_state(input logic [1:0] mode_code);
        state_t st;
        case (mode_code)
            MODE_BLINK: st = ST_BLINK;
            MODE_CHASE: st = ST_CHASE;
            MODE_FILL:  st = ST_FILL;
            MODE_OFF:   st = ST_IDLE;
            default:    st = ST_IDLE;
        endcase
        return st;
    endfunction

    // Starting pattern loaded whenever a state is (re)entered.
    function automatic logic [15:0] init_pattern(input state_t st);
        logic [15:0] pat;
        case (st)
            ST_BLINK: pat = PAT_BLINK;
            ST_CHASE: pat = PAT_CHASE;
            ST_FILL:  pat = PAT_FILL;
            ST_IDLE:  pat = PAT_IDLE;
            default:  pat = PAT_IDLE;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate divider: counts 0..TICK_DIV-1 while enabled, holds while
// disabled, and flags the terminal count as a one-cycle step tick.
// A clear (only honoured while enabled) restarts the count at 0.
module led_tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    import led_seq_pkg::*;

    localparam int               CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    // Divider counter: clear has priority, then wrap at terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (enable) begin
            if (clear) begin
                cnt_r <= '0;
            end else if (cnt_r == LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The tick marks the cycle whose closing edge performs a pattern step;
    // gating with enable keeps it silent while the sequencer is frozen.
    assign tick = enable && (cnt_r == LAST);

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: BLINK / CHASE / FILL / OFF patterns on 16 LEDs,
// stepped once every TICK_DIV enabled clock cycles.
// Optional build macro LED_SEQ_PWM_EN adds a 3-bit brightness input and a
// free-running PWM counter that gates the LED outputs.
module led_pattern_sequencer #(
    parameter int TICK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic        mode_load,
`ifdef LED_SEQ_PWM_EN
    input  logic [2:0]  brightness,
`endif
    output logic [15:0] led,
    output logic        busy,
    output logic        tick
);
    import led_seq_pkg::*;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] pat_r;
    logic [15:0] pat_s;
    logic        busy_r;
    logic        load_s;
    logic        tick_s;

    // A load is only accepted while running; it also restarts the divider.
    assign load_s = mode_load && enable;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .clear  (load_s),
        .tick   (tick_s)
    );

    // Next state and next pattern: a load beats a simultaneous tick.
    always_comb begin
        state_s = state_r;
        pat_s   = pat_r;
        if (load_s) begin
            state_s = mode_to_state(mode);
            pat_s   = init_pattern(mode_to_state(mode));
        end else if (tick_s) begin
            case (state_r)
                ST_BLINK: pat_s = ~pat_r;
                ST_CHASE: pat_s = {pat_r[14:0], pat_r[15]};
                ST_FILL:  pat_s = (pat_r == 16'hFFFF) ? 16'h0000 : {pat_r[14:0], 1'b1};
                ST_IDLE:  pat_s = PAT_IDLE;
                default:  pat_s = PAT_IDLE;
            endcase
        end else begin
            pat_s = pat_r;
        end
    end

    // State, pattern and busy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pat_r   <= PAT_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pat_r   <= pat_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [2:0]  pwm_cnt_r;
    logic [2:0]  pwm_cnt_s;
    logic [15:0] led_r;

    assign pwm_cnt_s = pwm_cnt_r + 3'd1;

    // Free-running PWM counter plus the dimmed LED register; the register
    // is fed with next-cycle values so led matches pat_r and pwm_cnt_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_r <= 3'd0;
            led_r     <= 16'h0000;
        end else begin
            pwm_cnt_r <= pwm_cnt_s;
            led_r     <= pat_s & {16{pwm_cnt_s <= brightness}};
        end
    end

    assign led = led_r;
`else
    assign led = pat_r;
`endif

    assign busy = busy_r;
    assign tick = tick_s;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer with TICK_DIV=4.
// A step-count model predicts led/busy/tick every cycle; directed checks
// with literal values pin the model at the interesting points.
module tb_led_pattern_sequencer;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        mode_load = 1'b0;
    logic [15:0] led;
    logic        busy;
    logic        tick;
`ifdef LED_SEQ_PWM_EN
    logic [2:0]  brightness = 3'd7;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    led_pattern_sequencer #(.TICK_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode       (mode),
        .mode_load  (mode_load),
`ifdef LED_SEQ_PWM_EN
        .brightness (brightness),
`endif
        .led        (led),
        .busy       (busy),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    // Model: active mode (3 = off/idle), steps taken since load, divider phase.
    int m_mode  = 3;
    int m_steps = 0;
    int m_phase = 0;

    // Pattern after k steps of a given mode, from the pattern definitions.
    function automatic logic [15:0] model_pat(input int md, input int k);
        int r;
        logic [31:0] v;
        case (md)
            0: v = ((k % 2) == 0) ? 32'h0000FFFF : 32'h00000000;
            1: v = 32'd1 << (k % 16);
            2: begin
                r = k % 17;
                v = (r == 16) ? 32'd0 : ((32'd1 << (r + 1)) - 32'd1);
            end
            default: v = 32'd0;
        endcase
        return v[15:0];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each edge; reset clears it asynchronously.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= 3;
            m_steps <= 0;
            m_phase <= 0;
        end else if (enable) begin
            if (mode_load) begin
                m_mode  <= int'(mode);
                m_steps <= 0;
                m_phase <= 0;
            end else begin
                if (m_phase == DIV - 1 && m_mode != 3) m_steps <= m_steps + 1;
                m_phase <= (m_phase + 1) % DIV;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on && rst_n) begin
            check("model_led", led, model_pat(m_mode, m_steps));
            check("model_busy", {15'd0, busy}, {15'd0, (m_mode != 3)});
            check("model_tick", {15'd0, tick}, {15'd0, (enable && m_phase == DIV - 1)});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] m);
        mode = m;
        mode_load = 1'b1;
        cyc(1);
        mode_load = 1'b0;
    endtask

    initial begin
        logic [15:0] e;
        int r;
        // Reset state, checked before any clock edge.
        #2;
        check("rst_led", led, 16'h0000);
        check("rst_busy", {15'd0, busy}, 16'h0000);
        check("rst_tick", {15'd0, tick}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_on = 1'b1;
        cyc(1);
        enable = 1'b1;
        cyc(6);
        check("idle_led", led, 16'h0000);

        // BLINK: FFFF, 4 cycles later 0000, then FFFF.
        load(2'b00);
        check("blink_init", led, 16'hFFFF);
        check("blink_busy", {15'd0, busy}, 16'h0001);
        cyc(4);
        check("blink_off", led, 16'h0000);
        cyc(4);
        check("blink_on", led, 16'hFFFF);

        // Load coincident with tick while BLINK shows FFFF: load wins.
        cyc(3);
        check("coinc_tick", {15'd0, tick}, 16'h0001);
        check("coinc_pre", led, 16'hFFFF);
        load(2'b01);
        check("coinc_led", led, 16'h0001);

        // CHASE over 16 ticks, including the wrap back to 0001.
        for (int i = 1; i <= 16; i++) begin
            cyc(4);
            e = 16'h0001 << (i % 16);
            check("chase", led, e);
        end

        // Freeze mid-CHASE at 0010 with a pending load of FILL.
        load(2'b01);
        cyc(16);
        check("chase_0010", led, 16'h0010);
        cyc(2);
        enable = 1'b0;
        mode = 2'b10;
        mode_load = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("frz_led", led, 16'h0010);
            check("frz_busy", {15'd0, busy}, 16'h0001);
            check("frz_tick", {15'd0, tick}, 16'h0000);
        end
        mode_load = 1'b0;
        enable = 1'b1;
        cyc(1);
        check("resume_tick", {15'd0, tick}, 16'h0001);
        check("resume_hold", led, 16'h0010);
        cyc(1);
        check("resume_step", led, 16'h0020);

        // FILL over 17 ticks: 0001..FFFF, 0000, 0001.
        load(2'b10);
        check("fill_init", led, 16'h0001);
        for (int i = 1; i <= 17; i++) begin
            cyc(4);
            r = i % 17;
            e = (r == 16) ? 16'h0000 : 16'hFFFF >> (15 - r);
            check("fill", led, e);
        end

        // Reset pulsed between edges mid-FILL.
        load(2'b10);
        cyc(8);
        check("fill_0007", led, 16'h0007);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_led", led, 16'h0000);
        check("arst_busy", {15'd0, busy}, 16'h0000);
        check("arst_tick", {15'd0, tick}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(10);
        check("post_rst_led", led, 16'h0000);
        check("post_rst_busy", {15'd0, busy}, 16'h0000);
        load(2'b01);
        check("post_rst_load", led, 16'h0001);
        check("post_rst_busy1", {15'd0, busy}, 16'h0001);

        // OFF returns to IDLE and ticks leave led dark.
        cyc(5);
        load(2'b11);
        check("off_led", led, 16'h0000);
        check("off_busy", {15'd0, busy}, 16'h0000);
        cyc(8);
        check("off_hold", led, 16'h0000);

        cyc(2);
        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
